sa_out_sched: RTL and testbench



---
 rtl/sa_out_sched.sv | 155 +++++++++++++++
 tb/tb_sa_out_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_out_sched.sv
// Output-port scheduler: round-robin over L/S/W, wormhole lock from head to tail,
// credit-based flow control toward the downstream input FIFO.
module sa_out_sched #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned DATASIZE = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req,
    input  logic [DATASIZE-1:0] L_data_in,
    input  logic [DATASIZE-1:0] S_data_in,
    input  logic [DATASIZE-1:0] W_data_in,
    input  logic                credit_in,
    output logic [2:0]          grant,
    output logic [DATASIZE-1:0] data_out,
    output logic                data_valid,
    output logic [WIDTH:0]      credit_cnt,
    output logic                locked,
    output logic [1:0]          owner
);

    localparam int unsigned CNT_W = WIDTH + 1;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          owner_q, owner_d;
    logic [CNT_W-1:0]    credit_q, credit_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    logic                credit_ok;
    logic [2:0]          pick;
    logic [1:0]          win;
    logic                found;
    logic [1:0]          sel;
    logic [DATASIZE-1:0] flit;
    logic [1:0]          flit_type;
    logic                send;

    // First requester in order p, p+1, p+2 (mod 3); returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [2:0] sum;
        logic [1:0] c;
        res = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            sum = {1'b0, p} + 3'(k);
            c   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    always_comb begin
        credit_ok = (credit_q != '0);
        pick      = rr_pick(req, ptr_q);
        found     = pick[2];
        win       = pick[1:0];
        sel       = (state_q == LOCK) ? owner_q : win;
        case (sel)
            2'd0:    flit = L_data_in;
            2'd1:    flit = S_data_in;
            default: flit = W_data_in;
        endcase
        flit_type = flit[1:0];
    end

    // Next-state and grant; grant is the only combinational output.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant   = 3'b000;
        case (state_q)
            IDLE: begin
                if (ptr_q == 2'd3) begin
                    ptr_d = 2'd0;
                end else if (found && credit_ok) begin
                    grant = 3'(3'b001 << win);
                    ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    if (flit_type == FT_HEAD) begin
                        state_d = LOCK;
                        owner_d = win;
                    end
                end
            end
            LOCK: begin
                if (owner_q == 2'd3) begin
                    state_d = IDLE;
                    ptr_d   = 2'd0;
                end else if (req[owner_q] && credit_ok) begin
                    grant = 3'(3'b001 << owner_q);
                    if (flit_type == FT_TAIL) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 2'd0;
            end
        endcase
        if (rst) begin
            grant = 3'b000;
        end
    end

    // Credit counter and output datapath.
    always_comb begin
        send     = |grant;
        credit_d = credit_q;
        case ({send, credit_in})
            2'b10: credit_d = credit_q - CNT_W'(1);
            2'b01: credit_d = (credit_q == CNT_W'(DEPTH)) ? credit_q : credit_q + CNT_W'(1);
            default: credit_d = credit_q;
        endcase
        data_d  = send ? flit : data_q;
        valid_d = send;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            owner_q  <= 2'd0;
            credit_q <= CNT_W'(DEPTH);
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign credit_cnt = credit_q;
    assign locked     = (state_q == LOCK);
    assign owner      = owner_q;

endmodule

// File: tb/tb_sa_out_sched.sv
// Randomized and directed checks of sa_out_sched against a behavioural model
// of round-robin arbitration, wormhole locking and credit accounting.
module tb_sa_out_sched;

    localparam int DEPTH = 8;
    localparam int WIDTH = 3;
    localparam int DS    = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req = 3'b000;
    logic [DS-1:0] L_data_in = '0;
    logic [DS-1:0] S_data_in = '0;
    logic [DS-1:0] W_data_in = '0;
    logic          credit_in = 1'b0;
    logic [2:0]    grant;
    logic [DS-1:0] data_out;
    logic          data_valid;
    logic [WIDTH:0] credit_cnt;
    logic          locked;
    logic [1:0]    owner;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit            m_locked;
    int            m_owner;
    int            m_ptr;
    int            m_cred;
    bit            m_valid;
    logic [DS-1:0] m_data;
    logic [2:0]    g_obs;
    logic [2:0]    g_exp;

    sa_out_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DS)) dut (
        .clk(clk), .rst(rst), .req(req),
        .L_data_in(L_data_in), .S_data_in(S_data_in), .W_data_in(W_data_in),
        .credit_in(credit_in), .grant(grant), .data_out(data_out),
        .data_valid(data_valid), .credit_cnt(credit_cnt),
        .locked(locked), .owner(owner)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, sample grant, predict, then advance the model.
    task automatic cycle(input logic [2:0] r, input logic [1:0] tl, input logic [1:0] ts,
                         input logic [1:0] tw, input logic ci);
        logic [DS-1:0] f [3];
        int w;
        @(negedge clk);
        for (int i = 0; i < 3; i++) f[i] = {8'($urandom()), 32'($urandom())};
        f[0][1:0] = tl;
        f[1][1:0] = ts;
        f[2][1:0] = tw;
        req = r; L_data_in = f[0]; S_data_in = f[1]; W_data_in = f[2]; credit_in = ci;
        #1;
        g_obs = grant;
        w = -1;
        if (!rst && m_cred > 0) begin
            if (m_locked) begin
                if (r[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < 3; k++)
                    if (w < 0 && r[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
            end
        end
        g_exp = (w >= 0) ? 3'(1 << w) : 3'b000;
        @(posedge clk);
        #1;
        if (rst) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH; m_valid = 0; m_data = '0;
        end else begin
            if (w >= 0) begin
                m_data  = f[w];
                m_valid = 1;
                m_cred  = m_cred - 1;
                if (m_locked) begin
                    if (f[w][1:0] == 2'b11) m_locked = 0;
                end else begin
                    m_ptr = (w + 1) % 3;
                    if (f[w][1:0] == 2'b01) begin m_locked = 1; m_owner = w; end
                end
            end else begin
                m_valid = 0;
            end
            if (ci && m_cred < DEPTH) m_cred = m_cred + 1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b1);
        cycle(3'b111, 2'b01, 2'b01, 2'b01, 1'b0);
        total++; if (g_obs !== 3'b000) begin bad++; $display("FAIL reset_grant obs=%b exp=000", g_obs); end
        total++; if (credit_cnt !== 4'(DEPTH)) begin bad++; $display("FAIL reset_credit obs=%0d exp=%0d", credit_cnt, DEPTH); end
        total++; if (data_valid !== 1'b0 || data_out !== '0) begin bad++; $display("FAIL reset_data valid=%b data=%h exp 0/0", data_valid, data_out); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked obs=%b exp=0", locked); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] order [3];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b1);
            total++; if (g_obs !== order[i % 3] || g_obs !== g_exp) begin bad++; $display("FAIL rr_grant[%0d] obs=%b exp=%b", i, g_obs, order[i % 3]); end
            total++; if (data_valid !== 1'b1 || data_out !== m_data) begin bad++; $display("FAIL rr_data[%0d] valid=%b data=%h exp=%h", i, data_valid, data_out, m_data); end
        end
    endtask

    task automatic test_wormhole();
        logic [1:0] pkt [4];
        pkt[0] = 2'b01; pkt[1] = 2'b10; pkt[2] = 2'b10; pkt[3] = 2'b11;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(3'b111, pkt[i], 2'b00, 2'b00, 1'b1);
            total++; if (g_obs !== 3'b001) begin bad++; $display("FAIL worm_grant[%0d] obs=%b exp=001", i, g_obs); end
            total++; if (locked !== (i < 3) || data_out !== m_data) begin bad++; $display("FAIL worm_lock[%0d] locked=%b exp=%b data=%h exp=%h", i, locked, (i < 3), data_out, m_data); end
        end
        cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b1);
        total++; if (g_obs !== 3'b010) begin bad++; $display("FAIL worm_after_tail obs=%b exp=010", g_obs); end
    endtask

    task automatic test_credits();
        int n;
        apply_reset();
        n = 0;
        for (int i = 0; i < 11; i++) begin
            cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b0);
            if (g_obs != 3'b000) n++;
        end
        total++; if (n != DEPTH) begin bad++; $display("FAIL cred_grants obs=%0d exp=%0d", n, DEPTH); end
        total++; if (credit_cnt !== '0) begin bad++; $display("FAIL cred_zero obs=%0d exp=0", credit_cnt); end
        cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b1);
        total++; if (g_obs !== 3'b000) begin bad++; $display("FAIL cred_no_bypass obs=%b exp=000", g_obs); end
        cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b0);
        total++; if (g_obs === 3'b000 || g_obs !== g_exp) begin bad++; $display("FAIL cred_one_more obs=%b exp=%b", g_obs, g_exp); end
        cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b0);
        total++; if (g_obs !== 3'b000) begin bad++; $display("FAIL cred_stop obs=%b exp=000", g_obs); end
    endtask

    task automatic test_credit_edges();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(3'b001, 2'b00, 2'b00, 2'b00, 1'b0);
        total++; if (credit_cnt !== 4'd5) begin bad++; $display("FAIL cred_five obs=%0d exp=5", credit_cnt); end
        cycle(3'b001, 2'b00, 2'b00, 2'b00, 1'b1);
        total++; if (g_obs !== 3'b001 || credit_cnt !== 4'd5) begin bad++; $display("FAIL cred_send_and_return grant=%b cnt=%0d exp 001/5", g_obs, credit_cnt); end
        apply_reset();
        cycle(3'b000, 2'b00, 2'b00, 2'b00, 1'b1);
        total++; if (credit_cnt !== 4'(DEPTH)) begin bad++; $display("FAIL cred_saturate obs=%0d exp=%0d", credit_cnt, DEPTH); end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        cycle(3'b100, 2'b00, 2'b00, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) cycle(3'b100, 2'b00, 2'b00, 2'b10, 1'b0);
        total++; if (locked !== 1'b1 || owner !== 2'd2 || credit_cnt !== 4'd3) begin bad++; $display("FAIL midpkt_setup locked=%b owner=%0d cnt=%0d exp 1/2/3", locked, owner, credit_cnt); end
        rst = 1'b1;
        cycle(3'b111, 2'b00, 2'b00, 2'b10, 1'b0);
        rst = 1'b0;
        total++; if (g_obs !== 3'b000) begin bad++; $display("FAIL midpkt_rst_grant obs=%b exp=000", g_obs); end
        total++; if (locked !== 1'b0 || credit_cnt !== 4'(DEPTH) || data_valid !== 1'b0) begin bad++; $display("FAIL midpkt_rst locked=%b cnt=%0d valid=%b exp 0/8/0", locked, credit_cnt, data_valid); end
        cycle(3'b110, 2'b00, 2'b00, 2'b00, 1'b0);
        total++; if (g_obs !== 3'b010) begin bad++; $display("FAIL midpkt_next obs=%b exp=010", g_obs); end
    endtask

    task automatic test_idle_body();
        apply_reset();
        cycle(3'b100, 2'b00, 2'b00, 2'b10, 1'b0);
        total++; if (g_obs !== 3'b100 || locked !== 1'b0) begin bad++; $display("FAIL idle_body grant=%b locked=%b exp 100/0", g_obs, locked); end
        cycle(3'b111, 2'b00, 2'b00, 2'b00, 1'b0);
        total++; if (g_obs !== 3'b001) begin bad++; $display("FAIL idle_body_ptr obs=%b exp=001", g_obs); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            cycle(3'($urandom()), 2'($urandom()), 2'($urandom()), 2'($urandom()),
                  ($urandom_range(0, 2) != 0));
            total++; if (g_obs !== g_exp) begin bad++; $display("FAIL rand_grant[%0d] obs=%b exp=%b", i, g_obs, g_exp); end
            total++; if (data_valid !== m_valid || data_out !== m_data) begin bad++; $display("FAIL rand_data[%0d] valid=%b data=%h exp %b/%h", i, data_valid, data_out, m_valid, m_data); end
            total++; if (credit_cnt !== 4'(m_cred)) begin bad++; $display("FAIL rand_credit[%0d] obs=%0d exp=%0d", i, credit_cnt, m_cred); end
            total++; if (locked !== m_locked || (m_locked && owner !== 2'(m_owner))) begin bad++; $display("FAIL rand_lock[%0d] locked=%b owner=%0d exp %b/%0d", i, locked, owner, m_locked, m_owner); end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH; m_valid = 0; m_data = '0;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credits();
        test_credit_edges();
        test_reset_mid_packet();
        test_idle_body();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
